// File: rtl/run_ctrl_fsm_chk.sv
// Run-control core: IDLE -> START -> RUN (timed) -> STOP, with command/state
// checking, illegal-state recovery and a saturating error counter.
module run_ctrl_fsm_chk #(
  parameter int STATE_W = 3,
  parameter int RUN_LEN = 8,
  parameter int ERR_W   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  input  logic [2:0]         cmd_i,
  input  logic               clr_err_i,
  input  logic               dbg_force_valid_i,
  input  logic [STATE_W-1:0] dbg_force_state_i,
  output logic [STATE_W-1:0] state_out_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               illegal_cmd_o,
  output logic               state_err_o,
  output logic               err_flag_o,
  output logic [ERR_W-1:0]   err_cnt_o
);

  localparam int CNT_W = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RUN_LEN - 1);

  typedef enum logic [STATE_W-1:0] {
    IDLE  = STATE_W'(0),
    START = STATE_W'(1),
    RUN   = STATE_W'(2),
    STOP  = STATE_W'(3)
  } state_e;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               err_flag_q, err_flag_d;
  logic               illegal_cmd_q, state_err_q;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic cmd_start, cmd_stop, cmd_abort, cmd_illegal;
  logic state_legal;
  logic ill_det, serr_det, err_event;

  assign state_legal = (state_q <= STATE_W'(3));

  // Reserved codes and any X/Z bit fall through to the default branch.
  always_comb begin
    cmd_start   = 1'b0;
    cmd_stop    = 1'b0;
    cmd_abort   = 1'b0;
    cmd_illegal = 1'b0;
    if (cmd_valid_i) begin
      case (cmd_i)
        3'd0:    ;
        3'd1:    cmd_start   = 1'b1;
        3'd2:    cmd_stop    = 1'b1;
        3'd3:    cmd_abort   = 1'b1;
        default: cmd_illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ill_det  = 1'b0;
    serr_det = 1'b0;
    if (dbg_force_valid_i) begin
      state_d = dbg_force_state_i;
      cnt_d   = '0;
    end else if (!state_legal) begin
      state_d  = IDLE;
      cnt_d    = '0;
      serr_det = 1'b1;
    end else if (cmd_illegal) begin
      ill_det = 1'b1;
    end else if (cmd_abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_start) state_d = START;
        end
        START: begin
          state_d = RUN;
          cnt_d   = CNT_LOAD;
        end
        RUN: begin
          if (cmd_stop || (cnt_q == '0)) begin
            state_d = STOP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        STOP: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A clear coinciding with an event leaves exactly that one event recorded.
  assign err_event = ill_det | serr_det;

  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    if (clr_err_i) begin
      err_cnt_d  = err_event ? ERR_W'(1) : '0;
      err_flag_d = err_event;
    end else if (err_event) begin
      if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
      err_flag_d = 1'b1;
    end
  end

  always_comb begin
    busy_d = (state_d == START) || (state_d == RUN) || (state_d == STOP);
    done_d = (state_d == STOP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      err_cnt_q     <= '0;
      err_flag_q    <= 1'b0;
      illegal_cmd_q <= 1'b0;
      state_err_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      err_cnt_q     <= err_cnt_d;
      err_flag_q    <= err_flag_d;
      illegal_cmd_q <= ill_det;
      state_err_q   <= serr_det;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign state_out_o   = state_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign illegal_cmd_o = illegal_cmd_q;
  assign state_err_o   = state_err_q;
  assign err_flag_o    = err_flag_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: doc/run_ctrl_fsm_chk.md
Name: run_ctrl_fsm_chk

Overview:
- Parametrised run-control state machine with four legal states: IDLE, START, RUN, STOP.
- Accepts encoded commands and times the RUN phase with an internal counter.
- Detects illegal commands (reserved codes, and X/Z bits in simulation) and illegal state-register encodings, then recovers to IDLE.
- Keeps a saturating error counter and a sticky error flag; used as the control core for sequenced datapath blocks.

Parameters:
- STATE_W, 3: state register width, minimum 2. Legal encodings are IDLE=0, START=1, RUN=2, STOP=3; every other value is illegal.
- RUN_LEN, 8: number of cycles spent in RUN when no STOP arrives, minimum 1.
- ERR_W, 4: width of the error counter.

Ports:
- clk, input, 1: clock; all logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- cmd_valid, input, 1: cmd is sampled only when this is high.
- cmd, input, 3: 0=NOP, 1=START, 2=STOP, 3=ABORT; 4..7 are reserved (illegal).
- clr_err, input, 1: clears err_cnt and err_flag.
- dbg_force_valid, input, 1: when high, loads dbg_force_state into the state register.
- dbg_force_state, input, STATE_W: value loaded by the debug force.
- state_out, output, STATE_W: current state register value.
- busy, output, 1: high in START, RUN or STOP.
- done, output, 1: high for the single cycle spent in STOP.
- illegal_cmd, output, 1: registered one-cycle pulse on an illegal command.
- state_err, output, 1: registered one-cycle pulse on an illegal state.
- err_flag, output, 1: sticky error flag.
- err_cnt, output, ERR_W: saturating count of error events.

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, run counter=0, err_cnt=0, err_flag=0, illegal_cmd=0, state_err=0. Consequently busy=0 and done=0. Reset overrides every other input; a reset asserted mid-RUN returns to IDLE on the next edge.
- Priority per edge: rst, then dbg_force_valid, then illegal-state recovery, then ABORT, then the normal transitions below.
- Normal transitions:
  - IDLE: START -> START. STOP, NOP or no command -> stay in IDLE.
  - START: -> RUN unconditionally; load run counter with RUN_LEN-1.
  - RUN: decrement the counter each cycle. A STOP command, or counter==0, -> STOP. RUN therefore lasts exactly RUN_LEN cycles when no STOP arrives. STOP wins over the counter reaching 0 in the same cycle (same destination).
  - STOP: -> IDLE unconditionally.
  - ABORT (valid, legal state): -> IDLE next edge from any state; the counter is cleared.
  - START received outside IDLE: ignored, not an error.
- Illegal command: cmd_valid=1 and cmd in 4..7, or any cmd bit X/Z (simulation; decode uses a default branch).
  - State and counter are held.
  - illegal_cmd=1 for one cycle, registered on the next edge.
- Illegal state: state register holds an encoding above 3 (reachable only via the debug force or an upset when STATE_W>2).
  - Next state is IDLE, the counter is cleared, state_err=1 for one cycle.
  - Any command in that cycle is ignored.
- Outputs busy and done decode only legal states; both are 0 in illegal states.
- Error accounting:
  - Each cycle with illegal_cmd or state_err detected counts as one error event, even if both occur together.
  - An event increments err_cnt, saturating at 2^ERR_W-1, and sets err_flag.
  - clr_err clears both. If an error event occurs in the same cycle as clr_err, the result is err_cnt=1 and err_flag=1.
- dbg_force_valid: the state register takes dbg_force_state on the next edge and the counter is cleared. A legal forced value resumes normal operation; an illegal one is caught the following cycle.

Test Plan:
- Nominal run (RUN_LEN=4): START at cycle 0 -> state_out is 1 at cycle 1, 2 at cycles 2-5, 3 at cycle 6 (done=1), 0 at cycle 7. busy=1 over cycles 1-6.
- Early stop: STOP issued on the 2nd RUN cycle -> STOP on the next edge, done pulses once, then IDLE. An ABORT mid-RUN -> IDLE next edge with done=0.
- Illegal command: cmd=5 in RUN, then cmd=3'bx1x -> illegal_cmd pulses twice, state is held each time, err_cnt=2, err_flag=1.
- Illegal state: force state 6 (STATE_W=3) -> state_err pulses once, IDLE on the following edge, err_cnt increments by 1. Also issue cmd=7 in that same cycle -> err_cnt still increments by only 1.
- Saturation and clear (ERR_W=2): 5 error events -> err_cnt=3. Pulse clr_err alone -> err_cnt=0, err_flag=0. clr_err together with an error -> err_cnt=1.
- Reset mid-RUN: assert rst at counter=2 -> next edge gives state=IDLE with every output 0. A START after release gives a full RUN_LEN run.
